// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounced push-button front end with per-button
// press/long-press FSMs and a round-robin valid/ready event stream.
//
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   btn_in[NUM_BTNS]      raw buttons (async, active-high)
//   clean_out[NUM_BTNS]   debounced levels
//   evt_valid_out/evt_ready_in   event handshake
//   evt_id_out, evt_type_out     0=PRESS 1=RELEASE 2=LONG 3=REPEAT
//   overflow_out          sticky: a pending event was overwritten
//
// Optional: define BTN_EVT_REPEAT_EN to build auto-repeat in HLD.

module btn_event_ctrl #(
  parameter int NUM_BTNS       = 4,
  parameter int TICK_CYCLES    = 100_000,
  parameter int DEBOUNCE_TICKS = 5,
  parameter int LONG_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100,
  localparam int IDW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] clean_out,
  output logic                evt_valid_out,
  input  logic                evt_ready_in,
  output logic [IDW-1:0]      evt_id_out,
  output logic [1:0]          evt_type_out,
  output logic                overflow_out
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int CW = IDW + 1;

  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0]  DB_LAST   = SW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [CW-1:0]  NB        = CW'(NUM_BTNS);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_BTNS - 1);

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;

  if (NUM_BTNS < 1 || NUM_BTNS > 16 ||
      TICK_CYCLES < 1 || DEBOUNCE_TICKS < 1 ||
      LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("btn_event_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    HLD = 2'd2
  } state_t;

  // two-flop synchroniser
  logic [NUM_BTNS-1:0] sync_q1;
  logic [NUM_BTNS-1:0] sync_q2;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // shared free-running prescaler
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // debounce: toggle on the tick that completes the stable run
  logic [NUM_BTNS-1:0]         clean_q;
  logic [NUM_BTNS-1:0][SW-1:0] stab_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clean_q <= '0;
      stab_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (sync_q2[i] == clean_q[i]) begin
          stab_q[i] <= '0;
        end else if (tick) begin
          if (stab_q[i] == DB_LAST) begin
            clean_q[i] <= ~clean_q[i];
            stab_q[i]  <= '0;
          end else begin
            stab_q[i] <= stab_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign clean_out = clean_q;

  // per-button press FSM
  state_t                      st_q [NUM_BTNS];
  state_t                      st_d [NUM_BTNS];
  logic [NUM_BTNS-1:0][HW-1:0] hold_q;
  logic [NUM_BTNS-1:0][HW-1:0] hold_d;
  logic [NUM_BTNS-1:0]         post;
  logic [NUM_BTNS-1:0][1:0]    post_ty;

`ifdef BTN_EVT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  logic [NUM_BTNS-1:0][RW-1:0] rep_q;
  logic [NUM_BTNS-1:0][RW-1:0] rep_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        st_q[i] <= REL;
      end
      hold_q <= '0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    hold_d  = hold_q;
    post    = '0;
    post_ty = '0;
`ifdef BTN_EVT_REPEAT_EN
    rep_d   = '0;
`endif
    for (int i = 0; i < NUM_BTNS; i++) begin
`ifdef BTN_EVT_REPEAT_EN
      if (st_q[i] == HLD) begin
        rep_d[i] = rep_q[i];
      end
`endif
      unique case (st_q[i])
        REL: begin
          if (clean_q[i]) begin
            st_d[i]    = PRS;
            hold_d[i]  = '0;
            post[i]    = 1'b1;
            post_ty[i] = EVT_PRESS;
          end
        end
        PRS: begin
          if (!clean_q[i]) begin
            st_d[i]    = REL;
            post[i]    = 1'b1;
            post_ty[i] = EVT_RELEASE;
          end else if (tick) begin
            if (hold_q[i] == LONG_LAST) begin
              st_d[i]    = HLD;
              post[i]    = 1'b1;
              post_ty[i] = EVT_LONG;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
        end
        HLD: begin
          if (!clean_q[i]) begin
            st_d[i]    = REL;
            post[i]    = 1'b1;
            post_ty[i] = EVT_RELEASE;
`ifdef BTN_EVT_REPEAT_EN
            rep_d[i]   = '0;
          end else if (tick) begin
            if (rep_q[i] == REP_LAST) begin
              rep_d[i]   = '0;
              post[i]    = 1'b1;
              post_ty[i] = EVT_REPEAT;
            end else begin
              rep_d[i] = rep_q[i] + 1'b1;
            end
`endif
          end
        end
        default: begin
          st_d[i] = REL;
        end
      endcase
    end
  end

  // pending slots and round-robin arbiter
  logic [NUM_BTNS-1:0]      slot_v_q;
  logic [NUM_BTNS-1:0][1:0] slot_t_q;
  logic [NUM_BTNS-1:0]      gnt;
  logic [IDW-1:0]           ptr_q;
  logic [IDW-1:0]           gidx;
  logic [CW-1:0]            cand;
  logic                     found;
  logic                     load;

  // output register may refill in the same cycle it is accepted
  assign load = !evt_valid_out || evt_ready_in;

  always_comb begin
    found = 1'b0;
    gidx  = ptr_q;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= NB) begin
        cand = cand - NB;
      end
      if (!found && slot_v_q[cand[IDW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[IDW-1:0];
      end
    end
    if (load && found) begin
      gnt[gidx] = 1'b1;
    end
  end

  // a grant in the posting cycle drains the old event first
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_v_q     <= '0;
      slot_t_q     <= '0;
      overflow_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (post[i]) begin
          slot_v_q[i] <= 1'b1;
          slot_t_q[i] <= post_ty[i];
        end else if (gnt[i]) begin
          slot_v_q[i] <= 1'b0;
        end
      end
      if (|(post & slot_v_q & ~gnt)) begin
        overflow_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      evt_valid_out <= 1'b0;
      evt_id_out    <= '0;
      evt_type_out  <= '0;
      ptr_q         <= '0;
    end else if (load) begin
      evt_valid_out <= found;
      if (found) begin
        evt_id_out   <= gidx;
        evt_type_out <= slot_t_q[gidx];
        ptr_q        <= (gidx == LAST_ID) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule
